thor2023_dcinval_ctrl: RTL and testbench
========================================

Name: thor2023_dcinval_ctrl

Overview:
- Cache-maintenance sequencer directly upstream of the data-cache valid-bit array.
- Accepts invalidate-line and invalidate-all commands from the memory-op pipeline or CSR side through a ready/valid port, and queues them in order.
- Issues each command to the valid array as a one-cycle invce/invline/invall strobe, only in cycles free of line-fill writes (the array gives fills priority and ignores invce during wr).
- Returns a tagged completion pulse per command.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- TAGW, 4, width of the command tag echoed on completion.
- LOBIT, 6, low bit of the line index; passed through for the match logic.
- LINES, 256, cache lines per way; HIBIT = $clog2(LINES)-1+LOBIT.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset.
- cmd_valid, in, 1, command offered.
- cmd_rdy, out, 1, FIFO can accept.
- cmd_all, in, 1, 1 = invalidate all, 0 = invalidate line.
- cmd_adr, in, $bits(Address), physical address (line op only).
- cmd_tag, in, TAGW, command tag.
- fill_wr, in, 1, line-fill write to valid array this cycle.
- fill_adr, in, $bits(Address), fill address (for the collision counter).
- invce, out, 1, invalidate strobe to valid array.
- invline, out, 1, line invalidate qualifier.
- invall, out, 1, all-ways/all-lines qualifier.
- inv_adr, out, $bits(Address), address to valid array.
- done, out, 1, completion pulse.
- done_tag, out, TAGW, tag of the completed command.
- busy, out, 1, FIFO non-empty or FSM not IDLE.
- coll_cnt, out, 16, saturating count of fills to a line with a pending line-invalidate.

Behaviour:
- Reset: rst is synchronous, active-high. All outputs and the FIFO pointers/count go to 0, FSM to IDLE, and cmd_rdy is 0 during reset. Queued commands are discarded without a done.
- Acceptance: a command is accepted when cmd_valid && cmd_rdy at a clock edge. cmd_rdy = (count < DEPTH) and is registered-free (combinational from count). The FIFO is a circular buffer with pointer wrap at DEPTH.
- Full/empty: push and pop in the same cycle on a full FIFO is allowed; count is unchanged. A push on an empty FIFO is not visible to the FSM until the next cycle.
- FSM states:
  - IDLE: if FIFO non-empty, go to ISSUE.
  - ISSUE:
    - If fill_wr=1: stall, drive no strobe, remain in ISSUE.
    - Else: register invce=1 for exactly one cycle, with invline=~head.all, invall=head.all, inv_adr=head.adr. Pop the head and go to DONE.
  - DONE:
    - Pulse done=1 with done_tag = the popped tag for one cycle.
    - Next state is ISSUE if the FIFO is non-empty, else IDLE.
- Strobe exclusivity: invline and invall are never both 1. Both are 0 whenever invce=0. inv_adr holds its last value otherwise.
- Latency: a command accepted at edge N into an empty, idle controller drives invce in cycle N+2 and done in cycle N+3, plus one cycle per stalled fill_wr cycle. Sustained throughput is one command per 2 cycles.
- Ordering: commands complete strictly in acceptance order. invall does not squash earlier queued line ops; each still issues and completes.
- Fill interaction: the registered invce is never asserted in a cycle where fill_wr was 1 at the deciding edge. The fill source guarantees fill_wr is known one cycle early (fill_wr is sampled, not the array's wr of the same cycle).
- Collision counter: coll_cnt increments (saturating at 16'hFFFF) when fill_wr=1 and fill_adr[HIBIT:LOBIT] equals the adr index of any valid FIFO line-op entry. The invalidate still issues afterward, which is the required ordering.
- busy = (count != 0) || (state != IDLE).

Decomposition:
- Thor2023Pkg gets:
  - dcinval_cmd_t (struct: all, adr, tag).
  - dcinval_state_t enum {DCI_IDLE, DCI_ISSUE, DCI_DONE}.
- Sub-module thor2023_dcinval_fifo: DEPTH-entry synchronous FIFO of dcinval_cmd_t with count and per-entry valid bits exported for the collision compare.
- FSM, strobe registers and counter stay in the top module.

Test Plan:
- Reset then single line op: adr=0x0000_1240, tag=3 at edge 10 → invce=1, invline=1, inv_adr=0x1240 at cycle 12; done=1, done_tag=3 at cycle 13; busy 0 at cycle 14.
- Fill stall: queue invall tag=5, hold fill_wr=1 for 3 cycles → invce deferred exactly 3 cycles; invall=1, invline=0 on issue; no strobe during fill cycles.
- Full FIFO with DEPTH=4: push 4 commands back-to-back → cmd_rdy=0 after the 4th. Fifth command is held until the first pop, then accepted. Completion tags appear in order 0,1,2,3,4, one every 2 cycles.
- Mixed order: line(tag1), all(tag2), line(tag3) → strobes in that order, each with the correct qualifier; no dropped done.
- Collision: pending line op at index 0x49, fill_wr with fill_adr index 0x49 → coll_cnt 0→1; invalidate still issues after the fill. Non-matching index leaves coll_cnt unchanged.
- Reset mid-operation: assert rst with 3 queued commands while in ISSUE → next cycle invce=0, done=0, busy=0, cmd_rdy=0 during reset and 1 after; no done for flushed tags.

Source files
------------

// File: rtl/thor2023_dcinval_ctrl_pkg.sv
// Shared types for the data-cache invalidate sequencer: command record and FSM states.
package thor2023_dcinval_ctrl_pkg;

    localparam int DCI_ADRW     = 32;
    localparam int DCI_TAG_MAXW = 16;

    typedef logic [DCI_ADRW-1:0] address_t;

    // Tag field is sized for the widest tag any instance may echo back.
    typedef struct packed {
        logic                    all;
        address_t                adr;
        logic [DCI_TAG_MAXW-1:0] tag;
    } dcinval_cmd_t;

    typedef enum logic [1:0] {
        DCI_IDLE,
        DCI_ISSUE,
        DCI_DONE
    } dcinval_state_t;

endpackage

// File: rtl/thor2023_dcinval_ctrl_if.sv
// Ready/valid command port into the invalidate sequencer.
interface thor2023_dcinval_ctrl_if
    import thor2023_dcinval_ctrl_pkg::*;
#(
    parameter int TAGW = 4
);

    logic            cmd_valid;
    logic            cmd_rdy;
    logic            cmd_all;
    address_t        cmd_adr;
    logic [TAGW-1:0] cmd_tag;

    modport master (
        output cmd_valid,
        output cmd_all,
        output cmd_adr,
        output cmd_tag,
        input  cmd_rdy
    );

    modport slave (
        input  cmd_valid,
        input  cmd_all,
        input  cmd_adr,
        input  cmd_tag,
        output cmd_rdy
    );

endinterface

// File: rtl/thor2023_dcinval_ctrl_fifo.sv
// Circular command FIFO; exposes every slot and its valid bit for the fill-collision compare.
module thor2023_dcinval_ctrl_fifo
    import thor2023_dcinval_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  dcinval_cmd_t             push_data,
    input  logic                     pop,
    output dcinval_cmd_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output dcinval_cmd_t             entries [DEPTH],
    output logic [DEPTH-1:0]         vld
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    dcinval_cmd_t     mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DEPTH-1:0] vld_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != DEPTH_C) || do_pop);

    // Clear before set so a push+pop on a full FIFO keeps the reused slot valid.
    always_comb begin
        vld_nxt = vld;
        if (do_pop)  vld_nxt[rd_ptr] = 1'b0;
        if (do_push) vld_nxt[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            vld <= vld_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entries
        assign entries[g] = mem[g];
    end

endmodule

// File: rtl/thor2023_dcinval_ctrl.sv
// Invalidate sequencer: queues line/all invalidates and strobes the valid array in fill-free cycles.
module thor2023_dcinval_ctrl
    import thor2023_dcinval_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4,
    parameter int LOBIT = 6,
    parameter int LINES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    thor2023_dcinval_ctrl_if.slave  cmd,
    input  logic                    fill_wr,
    input  address_t                fill_adr,
    output logic                    invce,
    output logic                    invline,
    output logic                    invall,
    output address_t                inv_adr,
    output logic                    done,
    output logic [TAGW-1:0]         done_tag,
    output logic                    busy,
    output logic [15:0]             coll_cnt
);

    localparam int HIBIT = $clog2(LINES) - 1 + LOBIT;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    dcinval_state_t          state;
    dcinval_cmd_t            push_data;
    dcinval_cmd_t            head;
    dcinval_cmd_t            entries [DEPTH];
    logic [DEPTH-1:0]        vld;
    logic [CW-1:0]           count;
    logic                    push;
    logic                    pop;
    logic                    fifo_nempty;
    logic                    coll_hit;
    logic                    unused_bits;
    logic [DCI_TAG_MAXW-1:0] cur_tag;

    assign cmd.cmd_rdy = !rst && (count < DEPTH_C);
    assign push        = cmd.cmd_valid && cmd.cmd_rdy;
    assign push_data   = '{all: cmd.cmd_all, adr: cmd.cmd_adr, tag: DCI_TAG_MAXW'(cmd.cmd_tag)};
    assign fifo_nempty = (count != '0);
    assign pop         = (state == DCI_ISSUE) && !fill_wr && fifo_nempty;
    assign busy        = fifo_nempty || (state != DCI_IDLE);

    thor2023_dcinval_ctrl_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .entries   (entries),
        .vld       (vld)
    );

    // A fill landing on a line that still has a queued invalidate; all-ops are not counted.
    always_comb begin
        coll_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && !entries[i].all &&
                (entries[i].adr[HIBIT:LOBIT] == fill_adr[HIBIT:LOBIT]))
                coll_hit = 1'b1;
        end
        coll_hit = coll_hit && fill_wr;
    end

    always_comb begin
        unused_bits = ^fill_adr ^ ^cur_tag;
        for (int i = 0; i < DEPTH; i++) unused_bits = unused_bits ^ (^entries[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DCI_IDLE;
            invce    <= 1'b0;
            invline  <= 1'b0;
            invall   <= 1'b0;
            inv_adr  <= '0;
            done     <= 1'b0;
            done_tag <= '0;
            coll_cnt <= '0;
        end else begin
            invce   <= 1'b0;
            invline <= 1'b0;
            invall  <= 1'b0;
            done    <= 1'b0;
            if (coll_hit) coll_cnt <= sat_inc16(coll_cnt);
            case (state)
                DCI_IDLE: begin
                    if (fifo_nempty) state <= DCI_ISSUE;
                end
                DCI_ISSUE: begin
                    if (pop) begin
                        invce   <= 1'b1;
                        invline <= !head.all;
                        invall  <= head.all;
                        inv_adr <= head.adr;
                        state   <= DCI_DONE;
                    end else if (!fifo_nempty) begin
                        state <= DCI_IDLE;
                    end
                end
                DCI_DONE: begin
                    done     <= 1'b1;
                    done_tag <= TAGW'(cur_tag);
                    state    <= fifo_nempty ? DCI_ISSUE : DCI_IDLE;
                end
                default: state <= DCI_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pop) cur_tag <= head.tag;
    end

endmodule

// File: tb/tb_thor2023_dcinval_ctrl.sv
// Directed plus randomized bench for the invalidate sequencer, checked against a queue-based model.
module tb_thor2023_dcinval_ctrl;

    localparam int DEPTH = 4;

    typedef struct {
        bit          all;
        logic [31:0] adr;
        logic [3:0]  tag;
    } mcmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fill_wr;
    logic [31:0] fill_adr;
    logic        invce, invline, invall, done, busy;
    logic [31:0] inv_adr;
    logic [3:0]  done_tag;
    logic [15:0] coll_cnt;

    always #5 clk = ~clk;

    thor2023_dcinval_ctrl_if #(.TAGW(4)) cif ();

    thor2023_dcinval_ctrl #(
        .DEPTH (DEPTH),
        .TAGW  (4),
        .LOBIT (6),
        .LINES (256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cif),
        .fill_wr  (fill_wr),
        .fill_adr (fill_adr),
        .invce    (invce),
        .invline  (invline),
        .invall   (invall),
        .inv_adr  (inv_adr),
        .done     (done),
        .done_tag (done_tag),
        .busy     (busy),
        .coll_cnt (coll_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    mcmd_t       pend[$];
    logic [3:0]  iss[$];
    logic [3:0]  done_log[$];
    int          done_cyc[$];
    logic [1:0]  str_log[$];
    logic [15:0] coll_m;
    logic [31:0] last_adr_m;
    bit          prev_invce;
    bit          s_rst, s_fill, s_acc;
    logic [31:0] s_fadr;
    mcmd_t       s_cmd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] line_idx(input logic [31:0] a);
        return a[13:6];
    endfunction

    // Inputs are captured at the falling edge, the rising edge is applied, and the model is advanced.
    task automatic tick();
        bit         hit;
        logic [3:0] t;
        @(negedge clk);
        chk("cmd_rdy", 32'(cif.cmd_rdy), 32'(!rst && (pend.size() < DEPTH)));
        s_rst  = rst;
        s_fill = fill_wr;
        s_fadr = fill_adr;
        s_acc  = cif.cmd_valid && cif.cmd_rdy;
        s_cmd  = '{all: cif.cmd_all, adr: cif.cmd_adr, tag: cif.cmd_tag};
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) begin
            pend.delete();
            iss.delete();
            coll_m     = '0;
            last_adr_m = '0;
            prev_invce = 1'b0;
            chk("rst_invce", 32'(invce), 0);
            chk("rst_quals", 32'({invline, invall}), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_done_tag", 32'(done_tag), 0);
            chk("rst_inv_adr", inv_adr, 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_coll", 32'(coll_cnt), 0);
        end else begin
            hit = 1'b0;
            foreach (pend[i])
                if (!pend[i].all && line_idx(pend[i].adr) == line_idx(s_fadr)) hit = 1'b1;
            if (s_fill && hit && coll_m != 16'hFFFF) coll_m = coll_m + 16'd1;
            if (invce === 1'b1) begin
                str_log.push_back({invall, invline});
                chk("strobe_in_fill", 32'(s_fill), 0);
                chk("strobe_has_cmd", 32'(pend.size() > 0), 1);
                if (pend.size() > 0) begin
                    chk("strobe_invline", 32'(invline), 32'(!pend[0].all));
                    chk("strobe_invall", 32'(invall), 32'(pend[0].all));
                    chk("strobe_adr", inv_adr, pend[0].adr);
                    last_adr_m = pend[0].adr;
                    iss.push_back(pend[0].tag);
                    void'(pend.pop_front());
                end
            end else begin
                chk("idle_quals", 32'({invline, invall}), 0);
                chk("idle_adr_hold", inv_adr, last_adr_m);
            end
            chk("done_timing", 32'(done), 32'(prev_invce));
            if (done === 1'b1) begin
                chk("done_has_cmd", 32'(iss.size() > 0), 1);
                if (iss.size() > 0) begin
                    t = iss.pop_front();
                    chk("done_tag", 32'(done_tag), 32'(t));
                end
                done_log.push_back(done_tag);
                done_cyc.push_back(cyc);
            end
            prev_invce = (invce === 1'b1);
            if (s_acc) pend.push_back(s_cmd);
            chk("coll_cnt", 32'(coll_cnt), 32'(coll_m));
            chk("busy", 32'(busy), 32'((pend.size() != 0) || prev_invce));
        end
    endtask

    task automatic offer(input bit all, input logic [31:0] adr, input logic [3:0] tag);
        cif.cmd_valid = 1'b1;
        cif.cmd_all   = all;
        cif.cmd_adr   = adr;
        cif.cmd_tag   = tag;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 1);
    endtask

    initial begin
        bit          acc4;
        logic [15:0] c0;
        logic [31:0] r;
        rst = 1'b1;
        fill_wr = 1'b0;
        fill_adr = '0;
        cif.cmd_valid = 1'b0;
        cif.cmd_all = 1'b0;
        cif.cmd_adr = '0;
        cif.cmd_tag = '0;
        coll_m = '0;
        last_adr_m = '0;
        prev_invce = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single line op: strobe two cycles after acceptance, done one later
        offer(1'b0, 32'h0000_1240, 4'd3);
        tick();
        chk("t1_accept", 32'(s_acc), 1);
        cif.cmd_valid = 1'b0;
        tick();
        chk("t1_no_early_strobe", 32'(invce), 0);
        tick();
        chk("t1_invce", 32'(invce), 1);
        chk("t1_invline", 32'(invline), 1);
        chk("t1_inv_adr", inv_adr, 32'h0000_1240);
        tick();
        chk("t1_done", 32'(done), 1);
        chk("t1_done_tag", 32'(done_tag), 3);
        tick();
        chk("t1_busy_clear", 32'(busy), 0);

        // invall deferred by three fill cycles
        offer(1'b1, 32'hdead_bec0, 4'd5);
        tick();
        cif.cmd_valid = 1'b0;
        tick();
        fill_wr = 1'b1;
        repeat (3) begin
            tick();
            chk("t2_stall", 32'(invce), 0);
        end
        fill_wr = 1'b0;
        tick();
        chk("t2_invce", 32'(invce), 1);
        chk("t2_invall", 32'(invall), 1);
        chk("t2_invline", 32'(invline), 0);
        tick();
        chk("t2_done_tag", 32'({done, done_tag}), 32'({1'b1, 4'd5}));

        // fill FIFO while fills hold the sequencer, then drain five in order
        fill_wr = 1'b1;
        fill_adr = '0;
        for (int t = 0; t < 4; t++) begin
            offer(1'b0, 32'((t + 1) << 6), 4'(t));
            tick();
            chk("t3_accept", 32'(s_acc), 1);
        end
        chk("t3_full_rdy", 32'(cif.cmd_rdy), 0);
        offer(1'b0, 32'h0000_0140, 4'd4);
        fill_wr = 1'b0;
        done_log.delete();
        done_cyc.delete();
        acc4 = 1'b0;
        for (int k = 0; k < 40 && done_log.size() < 5; k++) begin
            tick();
            if (s_acc && s_cmd.tag == 4'd4) begin
                cif.cmd_valid = 1'b0;
                acc4 = 1'b1;
            end
        end
        chk("t3_fifth_accepted", 32'(acc4), 1);
        chk("t3_done_count", 32'(done_log.size()), 5);
        for (int i = 0; i < done_log.size(); i++) begin
            chk("t3_done_order", 32'(done_log[i]), 32'(i));
            if (i > 0) chk("t3_done_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 2);
        end
        wait_idle("t3_drain");

        // mixed line/all/line ordering
        done_log.delete();
        str_log.delete();
        offer(1'b0, 32'h0000_2000, 4'd1);
        tick();
        offer(1'b1, 32'h0000_0000, 4'd2);
        tick();
        offer(1'b0, 32'h0000_3040, 4'd3);
        tick();
        cif.cmd_valid = 1'b0;
        for (int k = 0; k < 20 && done_log.size() < 3; k++) tick();
        chk("t4_done_count", 32'(done_log.size()), 3);
        chk("t4_strobe_count", 32'(str_log.size()), 3);
        for (int i = 0; i < 3 && i < done_log.size(); i++)
            chk("t4_done_order", 32'(done_log[i]), 32'(i + 1));
        for (int i = 0; i < 3 && i < str_log.size(); i++)
            chk("t4_qualifier", 32'(str_log[i]), (i == 1) ? 32'd2 : 32'd1);
        wait_idle("t4_drain");

        // fill hitting a pending line index counts, a different index does not
        c0 = coll_cnt;
        str_log.delete();
        offer(1'b0, 32'h0000_1240, 4'd6);
        tick();
        cif.cmd_valid = 1'b0;
        fill_wr = 1'b1;
        fill_adr = 32'h0000_5278;
        tick();
        chk("t5_coll_inc", 32'(coll_cnt), 32'(c0 + 16'd1));
        fill_wr = 1'b0;
        wait_idle("t5_drain_hit");
        chk("t5_issued_after_fill", 32'(str_log.size()), 1);
        chk("t5_issue_adr", inv_adr, 32'h0000_1240);
        c0 = coll_cnt;
        offer(1'b0, 32'h0000_1240, 4'd7);
        tick();
        cif.cmd_valid = 1'b0;
        fill_wr = 1'b1;
        fill_adr = 32'h0000_1280;
        tick();
        chk("t5_coll_hold", 32'(coll_cnt), 32'(c0));
        fill_wr = 1'b0;
        wait_idle("t5_drain_miss");

        // reset while three commands wait in ISSUE
        fill_wr = 1'b1;
        for (int t = 0; t < 3; t++) begin
            offer(1'b0, 32'(t << 6), 4'(8 + t));
            tick();
        end
        cif.cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t6_invce", 32'(invce), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_rdy_in_reset", 32'(cif.cmd_rdy), 0);
        rst = 1'b0;
        fill_wr = 1'b0;
        #1;
        chk("t6_rdy_after", 32'(cif.cmd_rdy), 1);
        done_log.delete();
        repeat (10) tick();
        chk("t6_no_flushed_done", 32'(done_log.size()), 0);

        // randomized traffic over a few line indexes so collisions occur
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            r = $urandom;
            cif.cmd_valid = ($urandom_range(0, 2) != 0);
            cif.cmd_all = ($urandom_range(0, 4) == 0);
            cif.cmd_adr = (r & 32'hFFFF_C03F) | 32'($urandom_range(0, 3) << 6);
            cif.cmd_tag = 4'($urandom_range(0, 15));
            r = $urandom;
            fill_wr = ($urandom_range(0, 3) == 0);
            fill_adr = (r & 32'hFFFF_C03F) | 32'($urandom_range(0, 3) << 6);
            tick();
        end
        rst = 1'b0;
        cif.cmd_valid = 1'b0;
        fill_wr = 1'b0;
        wait_idle("rand_drain");
        chk("rand_model_empty", 32'(pend.size() + iss.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
